// File: rtl/fetch_queue_if.sv
// Fetch front-end bus: redirect input, instruction-memory request/response and decode-side output.
// Valid/ready rule: a transfer happens in a cycle where valid && ready are both high at the rising
// clock edge. The memory response channel has no ready: imem_resp_valid is always accepted.
interface fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data, out_ready,
    output imem_req_valid, imem_addr, out_valid, out_pc, out_instr
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data, out_ready,
    input  imem_req_valid, imem_addr, out_valid, out_pc, out_instr
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, keeps up to DEPTH requests in flight and
// returns responses in order through a PC-tagged queue; redirect flushes and drops stale data.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [XLEN-1:0]  pc_q    [DEPTH];
  logic [XLEN-1:0]  instr_q [DEPTH];
  logic [DEPTH-1:0] filled_q;
  ptr_t             head_q, fill_q, tail_q;
  cnt_t             count_q, pending_q, drop_q;
  logic [XLEN-1:0]  fetch_pc_q;

  logic     issue, pop, resp_keep, resp_drop;
  logic [CW:0] drop_sum;
  cnt_t     drop_flush;

  assign bus.imem_req_valid = !reset && !bus.redirect_valid && (count_q != cnt_t'(DEPTH));
  assign bus.imem_addr      = fetch_pc_q;
  assign bus.out_valid      = filled_q[head_q];
  assign bus.out_pc         = bus.out_valid ? pc_q[head_q]    : '0;
  assign bus.out_instr      = bus.out_valid ? instr_q[head_q] : '0;

  assign issue     = bus.imem_req_valid && bus.imem_req_ready;
  assign pop       = bus.out_valid && bus.out_ready;
  assign resp_drop = bus.imem_resp_valid && (drop_q != '0);
  assign resp_keep = bus.imem_resp_valid && (drop_q == '0);

  // On redirect every unanswered request becomes a response to discard; a response arriving
  // in the same cycle is already one of them.
  always_comb begin
    drop_sum   = {1'b0, drop_q} + {1'b0, pending_q};
    drop_flush = '0;
    if (bus.imem_resp_valid && (drop_sum != '0)) begin
      drop_sum = drop_sum - 1'b1;
    end
    if (drop_sum > (CW + 1)'(DEPTH)) begin
      drop_flush = cnt_t'(DEPTH);
    end else begin
      drop_flush = drop_sum[CW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      filled_q   <= '0;
      head_q     <= '0;
      fill_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      pending_q  <= '0;
      drop_q     <= '0;
      fetch_pc_q <= RESET_PC;
    end else if (bus.redirect_valid) begin
      filled_q   <= '0;
      head_q     <= '0;
      fill_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      pending_q  <= '0;
      drop_q     <= drop_flush;
      fetch_pc_q <= {bus.redirect_pc[XLEN-1:2], 2'b00};
    end else begin
      // Pop clears before fill sets: they only share an index when the queue is full and
      // entirely filled, where a kept response cannot legally arrive.
      if (pop) begin
        filled_q[head_q] <= 1'b0;
        head_q           <= head_q + ptr_t'(1);
      end
      if (resp_keep) begin
        filled_q[fill_q] <= 1'b1;
        fill_q           <= fill_q + ptr_t'(1);
      end
      if (resp_drop) begin
        drop_q <= drop_q - cnt_t'(1);
      end
      if (issue) begin
        filled_q[tail_q] <= 1'b0;
        tail_q           <= tail_q + ptr_t'(1);
        fetch_pc_q       <= fetch_pc_q + XLEN'(4);
      end
      count_q   <= count_q + cnt_t'(issue) - cnt_t'(pop);
      pending_q <= pending_q + cnt_t'(issue) - cnt_t'(resp_keep);
    end
  end

  // Payload storage needs no reset: the filled bits qualify every read.
  always_ff @(posedge clk) begin
    if (!reset && !bus.redirect_valid) begin
      if (issue) begin
        pc_q[tail_q] <= fetch_pc_q;
      end
      if (resp_keep) begin
        instr_q[fill_q] <= bus.imem_resp_data;
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a queued memory model answers requests in order one cycle
// after acceptance, a second instance covers the wrapping reset PC.
module tb_fetch_queue;
  logic clk;
  logic reset;

  fetch_queue_if #(.XLEN(32)) ifa ();
  fetch_queue_if #(.XLEN(32)) ifb ();

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] mem_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] b_log[$];
  logic        mem_en;

  // observations from the most recent step
  logic        acc, rv, ov;
  logic [31:0] acc_addr, opc, oin;

  function automatic logic [31:0] img(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: sample outputs at the falling edge, then run the memory model after the edge.
  task automatic step();
    @(negedge clk);
    rv       = ifa.imem_req_valid;
    acc      = ifa.imem_req_valid && ifa.imem_req_ready;
    acc_addr = ifa.imem_addr;
    ov       = ifa.out_valid;
    opc      = ifa.out_pc;
    oin      = ifa.out_instr;
    if (ifb.imem_req_valid) b_log.push_back(ifb.imem_addr);
    @(posedge clk);
    #1;
    ifa.redirect_valid = 1'b0;
    if (reset) begin
      mem_q.delete();
      ifa.imem_resp_valid = 1'b0;
      ifa.imem_resp_data  = '0;
    end else begin
      if (acc) mem_q.push_back(acc_addr);
      if (mem_en && mem_q.size() > 0) begin
        ifa.imem_resp_valid = 1'b1;
        ifa.imem_resp_data  = img(mem_q.pop_front());
      end else begin
        ifa.imem_resp_valid = 1'b0;
        ifa.imem_resp_data  = '0;
      end
    end
  endtask

  task automatic do_reset();
    reset              = 1'b1;
    ifa.redirect_valid = 1'b0;
    ifa.redirect_pc    = '0;
    ifa.imem_req_ready = 1'b0;
    ifa.out_ready      = 1'b0;
    mem_en             = 1'b0;
    step();
    step();
    check("rst_req_valid", {31'b0, rv}, 32'd0);
    check("rst_out_valid", {31'b0, ov}, 32'd0);
    check("rst_out_pc", opc, 32'd0);
    check("rst_out_instr", oin, 32'd0);
    reset = 1'b0;
  endtask

  task automatic expect_accept(input string tag, input logic [31:0] addr);
    check({tag, "_acc"}, {31'b0, acc}, 32'd1);
    check({tag, "_addr"}, acc_addr, addr);
  endtask

  task automatic expect_out(input string tag, input logic [31:0] pc);
    check({tag, "_ov"}, {31'b0, ov}, 32'd1);
    check({tag, "_pc"}, opc, pc);
    check({tag, "_instr"}, oin, img(pc));
  endtask

  task automatic expect_empty(input string tag);
    check({tag, "_ov"}, {31'b0, ov}, 32'd0);
    check({tag, "_pc"}, opc, 32'd0);
    check({tag, "_instr"}, oin, 32'd0);
  endtask

  initial begin
    reset               = 1'b1;
    ifa.redirect_valid  = 1'b0;
    ifa.redirect_pc     = '0;
    ifa.imem_req_ready  = 1'b0;
    ifa.imem_resp_valid = 1'b0;
    ifa.imem_resp_data  = '0;
    ifa.out_ready       = 1'b0;
    ifb.redirect_valid  = 1'b0;
    ifb.redirect_pc     = '0;
    ifb.imem_req_ready  = 1'b1;
    ifb.imem_resp_valid = 1'b0;
    ifb.imem_resp_data  = '0;
    ifb.out_ready       = 1'b0;
    mem_en              = 1'b0;

    // streaming with a 1-cycle memory
    do_reset();
    mem_en = 1'b1; ifa.imem_req_ready = 1'b1; ifa.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      expect_accept("stream", 32'(4 * i));
      if (i >= 2) expect_out("stream", 32'(4 * (i - 2)));
      else        expect_empty("stream_head");
    end
    ifa.imem_req_ready = 1'b0;
    step(); expect_out("stream_tail", 32'd24);
    step(); expect_out("stream_tail", 32'd28);
    step(); expect_empty("stream_done");

    // backpressure fills the queue, then drains in order
    do_reset();
    mem_en = 1'b1; ifa.imem_req_ready = 1'b1; ifa.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_accept("fill", 32'(4 * i));
    end
    for (int i = 0; i < 2; i++) begin
      step();
      check("full_req_valid", {31'b0, rv}, 32'd0);
      expect_out("full_hold", 32'd0);
    end
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(4 * i));
    ifa.out_ready = 1'b1;
    step();
    check("drain_req_valid", {31'b0, rv}, 32'd0);
    expect_out("drain", exp_q.pop_front());
    for (int i = 0; i < 3; i++) begin
      step();
      expect_accept("resume", 32'(16 + 4 * i));
      expect_out("drain", exp_q.pop_front());
    end
    step();
    expect_out("drain", exp_q.pop_front());
    check("drain_sb_empty", 32'(exp_q.size()), 32'd0);

    // redirect with three requests unanswered
    do_reset();
    mem_en = 1'b0; ifa.imem_req_ready = 1'b1; ifa.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_accept("inflight", 32'(4 * i));
    end
    ifa.redirect_valid = 1'b1; ifa.redirect_pc = 32'h0000_0103; mem_en = 1'b1;
    step();
    check("redir_req_valid", {31'b0, rv}, 32'd0);
    step();
    expect_accept("redir_target", 32'h0000_0100);
    expect_empty("redir_drop");
    for (int i = 0; i < 3; i++) begin
      step();
      expect_empty("redir_drop");
    end
    step(); expect_out("redir_first", 32'h0000_0100);
    step(); expect_out("redir_second", 32'h0000_0104);

    // redirect together with a response and a pop
    do_reset();
    ifa.imem_req_ready = 1'b1; ifa.out_ready = 1'b0;
    mem_en = 1'b1; step(); expect_accept("mix", 32'd0);
    mem_en = 1'b0; step(); expect_accept("mix", 32'd4);
    mem_en = 1'b1; step(); expect_accept("mix", 32'd8);
    expect_out("mix_head", 32'd0);
    ifa.redirect_valid = 1'b1; ifa.redirect_pc = 32'h0000_0200; ifa.out_ready = 1'b1;
    step();
    expect_out("mix_pop", 32'd0);
    check("mix_req_valid", {31'b0, rv}, 32'd0);
    step();
    expect_accept("mix_target", 32'h0000_0200);
    expect_empty("mix_stale");
    step(); expect_empty("mix_stale");
    step(); expect_out("mix_new", 32'h0000_0200);

    // reset while full with two responses outstanding
    do_reset();
    ifa.imem_req_ready = 1'b1; ifa.out_ready = 1'b0; mem_en = 1'b1;
    step(); expect_accept("prerst", 32'd0);
    step(); expect_accept("prerst", 32'd4);
    mem_en = 1'b0;
    step(); expect_accept("prerst", 32'd8);
    step(); expect_accept("prerst", 32'd12);
    step();
    check("prerst_full", {31'b0, rv}, 32'd0);
    expect_out("prerst_head", 32'd0);
    reset = 1'b1;
    step();
    step();
    check("midrst_req_valid", {31'b0, rv}, 32'd0);
    expect_empty("midrst");
    reset = 1'b0; mem_en = 1'b1;
    step();
    expect_accept("postrst", 32'd0);
    expect_empty("postrst");
    step();
    expect_empty("postrst_nostale");

    // wrapping reset PC on the second instance
    check("wrap_count", (b_log.size() >= 4) ? 32'd1 : 32'd0, 32'd1);
    if (b_log.size() >= 4) begin
      check("wrap_addr0", b_log[0], 32'hFFFF_FFF8);
      check("wrap_addr1", b_log[1], 32'hFFFF_FFFC);
      check("wrap_addr2", b_log[2], 32'h0000_0000);
      check("wrap_addr3", b_log[3], 32'h0000_0004);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
